// File: rtl/matrix_pe_mlane.sv
// LANES-wide multiply-accumulate engine: uop-driven beat count, registered adder tree, valid/ready result.
// Define MPE_SAT_EN for saturating accumulation with a sticky sat_o flag; otherwise the accumulator wraps.
module matrix_pe_mlane #(
    parameter int LANES  = 64,
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              ib_ctl_uop,
    input  logic                    ib_ctl_uop_valid,
    output logic                    ib_ctl_uop_ready,
    input  logic [LANES*ELEM_W-1:0] nram_mpe_neuron,
    input  logic                    nram_mpe_neuron_valid,
    output logic                    nram_mpe_neuron_ready,
    input  logic [LANES*ELEM_W-1:0] wram_mpe_weight,
    input  logic                    wram_mpe_weight_valid,
    output logic                    wram_mpe_weight_ready,
    output logic [ACC_W-1:0]        result,
    output logic                    vld_o,
    input  logic                    rdy_i,
    output logic                    sat_o
);

    localparam int PW = 2 * ELEM_W;
    localparam int SW = PW + $clog2(LANES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
    state_t state, state_nxt;

    logic [6:0]       count, beat;
    logic             mode, accept, psum_vld, psum_first;
    logic [PW-1:0]    opa, opb, prod;
    logic [SW-1:0]    tree_sum, psum;
    logic [ACC_W-1:0] psum_ext, base, acc, acc_nxt;
    logic             uop_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt             = state;
        ib_ctl_uop_ready      = 1'b0;
        nram_mpe_neuron_ready = 1'b0;
        wram_mpe_weight_ready = 1'b0;
        vld_o                 = 1'b0;
        accept                = 1'b0;
        unique case (state)
            IDLE: begin
                ib_ctl_uop_ready = 1'b1;
                if (ib_ctl_uop_valid) state_nxt = RUN;
            end
            RUN: begin
                // a beat pair is only ever consumed together
                nram_mpe_neuron_ready = wram_mpe_weight_valid;
                wram_mpe_weight_ready = nram_mpe_neuron_valid;
                accept = nram_mpe_neuron_valid & wram_mpe_weight_valid;
                if (accept && beat == count) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = OUT;
            OUT: begin
                vld_o = 1'b1;
                if (rdy_i) state_nxt = IDLE;
            end
        endcase
    end

    assign uop_take = (state == IDLE) && ib_ctl_uop_valid;

    always_comb begin
        opa      = '0;
        opb      = '0;
        prod     = '0;
        tree_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mode) begin
                opa = PW'($signed(nram_mpe_neuron[i*ELEM_W +: ELEM_W]));
                opb = PW'($signed(wram_mpe_weight[i*ELEM_W +: ELEM_W]));
            end else begin
                opa = PW'(nram_mpe_neuron[i*ELEM_W +: ELEM_W]);
                opb = PW'(wram_mpe_weight[i*ELEM_W +: ELEM_W]);
            end
            prod     = opa * opb;
            tree_sum = tree_sum + (mode ? SW'($signed(prod)) : SW'(prod));
        end
    end

`ifdef MPE_SAT_EN
    logic [ACC_W:0] wide;
    logic           sat_hit;
    logic           sat;
`endif

    always_comb begin
        psum_ext = mode ? ACC_W'($signed(psum)) : ACC_W'(psum);
        base     = psum_first ? '0 : acc;
`ifdef MPE_SAT_EN
        sat_hit = 1'b0;
        wide    = mode ? {base[ACC_W-1], base} + {psum_ext[ACC_W-1], psum_ext}
                       : {1'b0, base} + {1'b0, psum_ext};
        acc_nxt = wide[ACC_W-1:0];
        if (mode && (wide[ACC_W] != wide[ACC_W-1])) begin
            sat_hit = 1'b1;
            acc_nxt = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else if (!mode && wide[ACC_W]) begin
            sat_hit = 1'b1;
            acc_nxt = '1;
        end
`else
        acc_nxt = base + psum_ext;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            beat       <= '0;
            mode       <= 1'b0;
            psum       <= '0;
            psum_vld   <= 1'b0;
            psum_first <= 1'b0;
            acc        <= '0;
        end else begin
            psum_vld <= accept;
            if (uop_take) begin
                count <= ib_ctl_uop[6:0];
                mode  <= ib_ctl_uop[7];
                beat  <= '0;
            end
            if (accept) begin
                psum       <= tree_sum;
                psum_first <= (beat == 7'd0);
                beat       <= beat + 7'd1;
            end
            if (psum_vld) acc <= acc_nxt;
        end
    end

    assign result = acc;

`ifdef MPE_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      sat <= 1'b0;
        else if (uop_take)            sat <= 1'b0;
        else if (psum_vld && sat_hit) sat <= 1'b1;
    end
    assign sat_o = sat;
`else
    assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_pe_mlane.sv
// Self-checking bench for matrix_pe_mlane: constant vector table, random ops against a dot-product model,
// plus backpressure and mid-op reset sequences. A 24-bit accumulator instance runs in lockstep.
`timescale 1ns/1ps
module tb_matrix_pe_mlane;
    localparam int LANES = 64;
    localparam int EW    = 8;
    localparam int BW    = LANES * EW;
`ifdef MPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    uop;
    logic          uop_valid, uop_ready, uop_ready24;
    logic [BW-1:0] neuron, weight;
    logic          nvalid, wvalid, nready, wready, nready24, wready24;
    logic [31:0]   result;
    logic [23:0]   result24;
    logic          vld, vld24, rdy, sat, sat24;

    logic [BW-1:0] nb[128];
    logic [BW-1:0] wb[128];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  uop;
        logic [7:0]  n;
        logic [7:0]  w;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[7];

    always #5 clk = ~clk;

    matrix_pe_mlane #(.LANES(LANES), .ELEM_W(EW), .ACC_W(32)) dut (
        .clk(clk), .rst(rst),
        .ib_ctl_uop(uop), .ib_ctl_uop_valid(uop_valid), .ib_ctl_uop_ready(uop_ready),
        .nram_mpe_neuron(neuron), .nram_mpe_neuron_valid(nvalid), .nram_mpe_neuron_ready(nready),
        .wram_mpe_weight(weight), .wram_mpe_weight_valid(wvalid), .wram_mpe_weight_ready(wready),
        .result(result), .vld_o(vld), .rdy_i(rdy), .sat_o(sat)
    );

    matrix_pe_mlane #(.LANES(LANES), .ELEM_W(EW), .ACC_W(24)) dut24 (
        .clk(clk), .rst(rst),
        .ib_ctl_uop(uop), .ib_ctl_uop_valid(uop_valid), .ib_ctl_uop_ready(uop_ready24),
        .nram_mpe_neuron(neuron), .nram_mpe_neuron_valid(nvalid), .nram_mpe_neuron_ready(nready24),
        .wram_mpe_weight(weight), .wram_mpe_weight_valid(wvalid), .wram_mpe_weight_ready(wready24),
        .result(result24), .vld_o(vld24), .rdy_i(rdy), .sat_o(sat24)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic longint elem(input logic [BW-1:0] v, input int l, input bit sgn);
        logic [7:0] e;
        e = v[l*8 +: 8];
        if (sgn) return longint'($signed(e));
        return longint'(e);
    endfunction

    // Dot product over all beats, clamped per beat when saturating, then reduced to accw bits.
    function automatic logic [31:0] ref_result(input int nbeats, input bit sgn, input int accw,
                                               input bit satmode, output bit satflag);
        longint acc, s, lo, hi, mask;
        acc = 0;
        satflag = 1'b0;
        if (sgn) begin
            lo = -(longint'(1) << (accw - 1));
            hi = (longint'(1) << (accw - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << accw) - 1;
        end
        for (int b = 0; b < nbeats; b++) begin
            s = 0;
            for (int l = 0; l < LANES; l++) s += elem(nb[b], l, sgn) * elem(wb[b], l, sgn);
            acc += s;
            if (satmode && acc > hi) begin acc = hi; satflag = 1'b1; end
            if (satmode && acc < lo) begin acc = lo; satflag = 1'b1; end
        end
        mask = (longint'(1) << accw) - 1;
        return 32'(acc & mask);
    endfunction

    task automatic fill_uniform(input int nbeats, input logic [7:0] n, input logic [7:0] w);
        for (int b = 0; b < nbeats; b++)
            for (int l = 0; l < LANES; l++) begin
                nb[b][l*8 +: 8] = n;
                wb[b][l*8 +: 8] = w;
            end
    endtask

    task automatic fill_random(input int nbeats);
        for (int b = 0; b < nbeats; b++)
            for (int j = 0; j < BW / 32; j++) begin
                nb[b][j*32 +: 32] = $urandom;
                wb[b][j*32 +: 32] = $urandom;
            end
    endtask

    task automatic issue_uop(input logic [7:0] u);
        int cyc;
        cyc = 0;
        uop = u;
        uop_valid = 1'b1;
        while (!uop_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("uop_ready", 32'(uop_ready), 32'd1);
        @(negedge clk);
        uop_valid = 1'b0;
    endtask

    task automatic feed(input int nbeats, input bit gaps);
        int k, cyc;
        logic nacc, wacc;
        k = 0;
        cyc = 0;
        while (k < nbeats && cyc < 2000) begin
            nvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            neuron = nb[k];
            weight = wb[k];
            #1;
            nacc = nvalid & nready;
            wacc = wvalid & wready;
            if (nacc !== wacc) check("one_sided", {30'd0, nacc, wacc}, {30'd0, wacc, wacc});
            if (nacc) k++;
            @(negedge clk);
            cyc++;
        end
        nvalid = 1'b0;
        wvalid = 1'b0;
        check("beats_accepted", 32'(k), 32'(nbeats));
    endtask

    task automatic wait_out();
        check("vld_early", 32'(vld), 32'd0);
        @(negedge clk);
        check("vld_latency", 32'(vld), 32'd1);
    endtask

    task automatic release_out();
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        check("vld_drop", 32'(vld), 32'd0);
        check("idle_ready", 32'(uop_ready), 32'd1);
    endtask

    task automatic check_op(input string name, input logic [7:0] u);
        bit f32, f24;
        logic [31:0] e32, e24;
        e32 = ref_result(int'(u[6:0]) + 1, u[7], 32, SAT, f32);
        e24 = ref_result(int'(u[6:0]) + 1, u[7], 24, SAT, f24);
        check({name, "_res"}, result, e32);
        check({name, "_sat"}, 32'(sat), 32'(f32));
        check({name, "_res24"}, 32'(result24), e24);
        check({name, "_sat24"}, 32'(sat24), 32'(f24));
    endtask

    initial begin
        rst = 1'b1; uop = '0; uop_valid = 1'b0; neuron = '0; weight = '0;
        nvalid = 1'b0; wvalid = 1'b0; rdy = 1'b0;

        vt[0] = '{8'h82, 8'h01, 8'h02, 32'h0000_0180};
        vt[1] = '{8'h80, 8'hFF, 8'h01, 32'hFFFF_FFC0};
        vt[2] = '{8'h00, 8'hFF, 8'h01, 32'h0000_3FC0};
        vt[3] = '{8'h81, 8'h80, 8'h80, 32'h0020_0000};
        vt[4] = '{8'h01, 8'hFF, 8'hFF, 32'h007F_0080};
        vt[5] = '{8'h80, 8'h7F, 8'h80, 32'hFFF0_2000};
        vt[6] = '{8'h88, 8'h7F, 8'h7F, 32'h008D_C240};

        #2;
        check("rst_uop_ready", 32'(uop_ready), 32'd1);
        check("rst_nready", 32'(nready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            fill_uniform(int'(vt[i].uop[6:0]) + 1, vt[i].n, vt[i].w);
            issue_uop(vt[i].uop);
            feed(int'(vt[i].uop[6:0]) + 1, 1'b0);
            wait_out();
            check($sformatf("vec%0d_res", i), result, vt[i].exp);
            check_op($sformatf("vec%0d", i), vt[i].uop);
            if (i == 6) begin
                check("acc24_res", 32'(result24), SAT ? 32'h007F_FFFF : 32'h008D_C240);
                check("acc24_sat", 32'(sat24), SAT ? 32'd1 : 32'd0);
            end
            release_out();
        end

        for (int r = 0; r < 4; r++) begin
            logic [7:0] u;
            u = (r == 0) ? 8'hFF : 8'($urandom);
            fill_random(int'(u[6:0]) + 1);
            issue_uop(u);
            feed(int'(u[6:0]) + 1, 1'b1);
            wait_out();
            check_op($sformatf("rand%0d", r), u);
            release_out();
        end

        // Result held under backpressure while a new uop and stray beats wait.
        fill_uniform(3, 8'h03, 8'h05);
        issue_uop(8'h02);
        feed(3, 1'b0);
        wait_out();
        uop = 8'h80;
        uop_valid = 1'b1;
        nvalid = 1'b1;
        wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_result", result, 32'd2880);
            check("bp_vld", 32'(vld), 32'd1);
            check("bp_uop_ready", 32'(uop_ready), 32'd0);
            check("bp_nready", 32'(nready), 32'd0);
            @(negedge clk);
        end
        nvalid = 1'b0;
        wvalid = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        #1;
        check("bp_idle_ready", 32'(uop_ready), 32'd1);
        check("bp_vld_drop", 32'(vld), 32'd0);
        fill_uniform(1, 8'h03, 8'hFE);
        @(negedge clk);
        uop_valid = 1'b0;
        check("bp_uop_taken", 32'(uop_ready), 32'd0);
        feed(1, 1'b0);
        wait_out();
        check("bp_next_res", result, 32'hFFFF_FE80);
        check_op("bp_next", 8'h80);
        release_out();

        // Reset during the second beat of a three-beat op.
        fill_uniform(3, 8'h02, 8'h02);
        issue_uop(8'h82);
        feed(1, 1'b0);
        @(negedge clk);
        nvalid = 1'b1;
        wvalid = 1'b1;
        neuron = nb[1];
        weight = wb[1];
        rst = 1'b1;
        #1;
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_vld", 32'(vld), 32'd0);
        check("mid_rst_sat", 32'(sat), 32'd0);
        check("mid_rst_nready", 32'(nready), 32'd0);
        check("mid_rst_wready", 32'(wready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nvalid = 1'b0;
        wvalid = 1'b0;
        #1;
        check("post_rst_uop_ready", 32'(uop_ready), 32'd1);
        @(negedge clk);
        fill_uniform(1, 8'h03, 8'hFE);
        issue_uop(8'h80);
        feed(1, 1'b0);
        wait_out();
        check("post_rst_res", result, 32'hFFFF_FE80);
        check_op("post_rst", 8'h80);
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
